// File: rtl/uart_frame_pkg.sv
// Shared state, error-code and marker definitions for the UART command-frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_COMMIT,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: synchronous write, asynchronous read, indexed by byte position.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SOF/ADDR/LEN/DATA/CHK frames from the UART receiver and, once the
// checksum matches, replays the buffered payload as one register write per clock.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 2000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun,
    output logic       o_Busy
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_e           state_q;
    logic [7:0]       base_q;
    logic [7:0]       chk_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [1:0]       err_code_q;
    logic             wr_en_q;
    logic             done_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic             buf_we;
    logic [IDX_W-1:0] buf_rd_idx;
    logic [7:0]       buf_rd_data;
    logic [CNT_W-1:0] idx_next;
    logic             in_frame;
    logic             tmo_expired;

    // Word 0 is fetched while still in CHK so the first write leaves on the accepting edge.
    assign buf_we      = (state_q == ST_DATA) && i_Rx_DV;
    assign buf_rd_idx  = (state_q == ST_CHK) ? '0 : idx_q[IDX_W-1:0];
    assign idx_next    = idx_q + 1'b1;
    assign in_frame    = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    assign tmo_expired = in_frame && !i_Rx_DV && (tmo_q == TMO_LAST);

    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk_i     (i_Clock),
        .wr_en_i   (buf_we),
        .wr_idx_i  (idx_q[IDX_W-1:0]),
        .wr_data_i (i_Rx_Byte),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_code_q  <= ERR_NONE;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (in_frame) begin
                tmo_q <= i_Rx_DV ? '0 : tmo_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                        chk_q   <= '0;
                        tmo_q   <= '0;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (i_Rx_DV) begin
                        base_q  <= i_Rx_Byte;
                        chk_q   <= chk_q ^ i_Rx_Byte;
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_Rx_DV) begin
                        if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_LEN_B)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= ST_ERR;
                        end else begin
                            len_q   <= i_Rx_Byte[CNT_W-1:0];
                            chk_q   <= chk_q ^ i_Rx_Byte;
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_Rx_DV) begin
                        chk_q <= chk_q ^ i_Rx_Byte;
                        idx_q <= idx_next;
                        if (idx_next == len_q) begin
                            state_q <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == chk_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= base_q;
                            wr_data_q <= buf_rd_data;
                            idx_q     <= CNT_W'(1);
                            state_q   <= ST_COMMIT;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                            state_q     <= ST_ERR;
                        end
                    end
                end
                ST_COMMIT: begin
                    overrun_q <= i_Rx_DV;
                    if (idx_q == len_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= base_q + 8'(idx_q);
                        wr_data_q <= buf_rd_data;
                        idx_q     <= idx_next;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A timeout can only fire on a byte-less clock, so it never competes with a case branch above.
            if (tmo_expired) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= ST_ERR;
            end
        end
    end

    assign o_Wr_En      = wr_en_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Overrun    = overrun_q;
    assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scenario and randomized frame bench for uart_rx_frame_ctrl against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 2000;
    localparam logic [7:0] SOF     = 8'hA5;

    logic       i_Clock   = 1'b0;
    logic       i_Rst_n   = 1'b0;
    logic       i_Rx_DV   = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       o_Wr_En;
    logic [7:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic       o_Frame_Done;
    logic       o_Frame_Err;
    logic [1:0] o_Err_Code;
    logic       o_Overrun;
    logic       o_Busy;

    int nChecks = 0;
    int nFails  = 0;
    int edgeCnt = 0;

    logic [15:0] wq[$];
    int          wEdge[$];
    int          doneCnt = 0;
    int          doneEdge = 0;
    int          errCnt = 0;
    int          errEdge = 0;
    int          ovCnt = 0;

    logic [7:0] frameData [64];

    uart_rx_frame_ctrl #(
        .SOF_BYTE     (SOF),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Rst_n      (i_Rst_n),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Wr_En      (o_Wr_En),
        .o_Wr_Addr    (o_Wr_Addr),
        .o_Wr_Data    (o_Wr_Data),
        .o_Frame_Done (o_Frame_Done),
        .o_Frame_Err  (o_Frame_Err),
        .o_Err_Code   (o_Err_Code),
        .o_Overrun    (o_Overrun),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) edgeCnt++;

    // Event recorder: edgeCnt at a negedge names the rising edge that produced the sampled values.
    always @(negedge i_Clock) begin
        if (i_Rst_n) begin
            if (o_Wr_En) begin
                wq.push_back({o_Wr_Addr, o_Wr_Data});
                wEdge.push_back(edgeCnt);
            end
            if (o_Frame_Done) begin
                doneCnt++;
                doneEdge = edgeCnt;
            end
            if (o_Frame_Err) begin
                errCnt++;
                errEdge = edgeCnt;
            end
            if (o_Overrun) ovCnt++;
        end
    end

    task automatic clear_mon();
        wq.delete();
        wEdge.delete();
        doneCnt = 0;
        errCnt  = 0;
        ovCnt   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(negedge i_Clock);
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'($urandom);
    endtask

    task automatic gap(input int maxGap);
        repeat ($urandom_range(0, maxGap)) @(negedge i_Clock);
    endtask

    function automatic logic [7:0] garbage_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        return b;
    endfunction

    // Sends one frame and checks the outcome predicted from the frame rules.
    // chkMode: -1 correct checksum, -2 random wrong checksum, otherwise the literal byte to send.
    task automatic run_frame(input logic [7:0] addr, input logic [7:0] lenB, input int chkMode,
                             input bit injectOverrun, input int maxGap, input string name);
        logic [7:0]  chk;
        logic [7:0]  chkB;
        logic [15:0] expW[$];
        int          lenEdge;
        int          chkEdge;
        bit          lenOk;
        bit          chkOk;
        int          expOv;

        clear_mon();
        lenOk   = (lenB != 8'h00) && (int'(lenB) <= MAX_LEN);
        chk     = addr ^ lenB;
        chkEdge = 0;
        chkOk   = 1'b0;
        expOv   = 0;

        send_byte(SOF);
        gap(maxGap);
        send_byte(addr);
        gap(maxGap);
        send_byte(lenB);
        lenEdge = edgeCnt;

        if (lenOk) begin
            for (int i = 0; i < int'(lenB); i++) begin
                gap(maxGap);
                send_byte(frameData[i]);
                chk = chk ^ frameData[i];
                expW.push_back({addr + 8'(i), frameData[i]});
            end
            if (chkMode == -1)      chkB = chk;
            else if (chkMode == -2) chkB = chk ^ 8'($urandom_range(1, 255));
            else                    chkB = 8'(chkMode);
            chkOk = (chkB == chk);
            gap(maxGap);
            send_byte(chkB);
            chkEdge = edgeCnt;
            if (injectOverrun && chkOk) begin
                send_byte(8'($urandom));
                expOv = 1;
            end
        end

        repeat (MAX_LEN + 4) @(negedge i_Clock);

        if (!lenOk || !chkOk) begin
            nChecks++;
            if (errCnt !== 1) begin
                nFails++;
                $display("[TB] FAIL %s err_pulses: got %0d want 1", name, errCnt);
            end
            nChecks++;
            if (o_Err_Code !== (lenOk ? 2'b10 : 2'b01)) begin
                nFails++;
                $display("[TB] FAIL %s err_code: got %b want %b", name, o_Err_Code, lenOk ? 2'b10 : 2'b01);
            end
            nChecks++;
            if (errEdge !== (lenOk ? chkEdge : lenEdge)) begin
                nFails++;
                $display("[TB] FAIL %s err_timing: got edge %0d want %0d", name, errEdge, lenOk ? chkEdge : lenEdge);
            end
            nChecks++;
            if ((wq.size() !== 0) || (doneCnt !== 0)) begin
                nFails++;
                $display("[TB] FAIL %s no_writes: got %0d writes %0d done want 0 0", name, wq.size(), doneCnt);
            end
        end else begin
            nChecks++;
            if (wq.size() !== expW.size()) begin
                nFails++;
                $display("[TB] FAIL %s write_count: got %0d want %0d", name, wq.size(), expW.size());
            end else begin
                for (int i = 0; i < expW.size(); i++) begin
                    nChecks++;
                    if ((wq[i] !== expW[i]) || (wEdge[i] !== chkEdge + i)) begin
                        nFails++;
                        $display("[TB] FAIL %s write[%0d]: got %h at edge %0d want %h at edge %0d",
                                 name, i, wq[i], wEdge[i], expW[i], chkEdge + i);
                    end
                end
            end
            nChecks++;
            if ((doneCnt !== 1) || (doneEdge !== chkEdge + int'(lenB))) begin
                nFails++;
                $display("[TB] FAIL %s done: got %0d pulses at edge %0d want 1 at edge %0d",
                         name, doneCnt, doneEdge, chkEdge + int'(lenB));
            end
            nChecks++;
            if (errCnt !== 0) begin
                nFails++;
                $display("[TB] FAIL %s unexpected_err: got %0d want 0", name, errCnt);
            end
        end

        nChecks++;
        if (ovCnt !== expOv) begin
            nFails++;
            $display("[TB] FAIL %s overrun: got %0d want %0d", name, ovCnt, expOv);
        end
        nChecks++;
        if (o_Busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL %s busy_after: got %b want 0", name, o_Busy);
        end
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        repeat (3) @(negedge i_Clock);
        nChecks++;
        if ({o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Frame_Err, o_Overrun, o_Busy} !== 21'd0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Frame_Err, o_Overrun, o_Busy});
        end
        nChecks++;
        if (o_Err_Code !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL reset_err_code: got %b want 00", o_Err_Code);
        end
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clock);
        nChecks++;
        if (o_Busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_release_busy: got %b want 0", o_Busy);
        end
    endtask

    task automatic test_good_frame();
        frameData[0] = 8'h11;
        frameData[1] = 8'h22;
        frameData[2] = 8'h33;
        run_frame(8'h10, 8'h03, 8'h13, 1'b0, 0, "good_frame");
    endtask

    task automatic test_bad_checksum();
        frameData[0] = 8'hAA;
        frameData[1] = 8'hBB;
        run_frame(8'h20, 8'h02, 8'h00, 1'b0, 0, "bad_checksum");
    endtask

    task automatic test_bad_length();
        run_frame(8'h00, 8'h00, -1, 1'b0, 0, "len_zero");
        run_frame(8'h00, 8'h11, -1, 1'b0, 1, "len_over");
        for (int i = 0; i < 3; i++) send_byte(garbage_byte());
        repeat (3) @(negedge i_Clock);
        nChecks++;
        if ((o_Busy !== 1'b0) || (errCnt !== 1) || (wq.size() !== 0)) begin
            nFails++;
            $display("[TB] FAIL len_trailing_ignored: got busy %b errs %0d writes %0d want 0 1 0",
                     o_Busy, errCnt, wq.size());
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(SOF);
        send_byte(8'h40);
        repeat (TMO - 1) @(negedge i_Clock);
        nChecks++;
        if ((o_Frame_Err !== 1'b0) || (o_Busy !== 1'b1)) begin
            nFails++;
            $display("[TB] FAIL timeout_early: got err %b busy %b want 0 1", o_Frame_Err, o_Busy);
        end
        @(negedge i_Clock);
        nChecks++;
        if ((o_Frame_Err !== 1'b1) || (o_Err_Code !== 2'b11)) begin
            nFails++;
            $display("[TB] FAIL timeout_fire: got err %b code %b want 1 11", o_Frame_Err, o_Err_Code);
        end
        @(negedge i_Clock);
        nChecks++;
        if (o_Busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL timeout_busy: got %b want 0", o_Busy);
        end
        for (int i = 0; i < 5; i++) frameData[i] = 8'($urandom);
        run_frame(8'h55, 8'h05, -1, 1'b0, 2, "after_timeout");
    endtask

    task automatic test_wrap_and_garbage();
        send_byte(8'h00);
        send_byte(8'hFF);
        frameData[0] = 8'h01;
        frameData[1] = 8'h02;
        frameData[2] = 8'h03;
        frameData[3] = 8'h04;
        run_frame(8'hFE, 8'h04, 8'hFE, 1'b0, 0, "wrap");
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 6; i++) frameData[i] = 8'($urandom);
        run_frame(8'h80, 8'h06, -1, 1'b1, 0, "overrun");
    endtask

    task automatic test_reset_mid_commit();
        logic [7:0] chk;
        bit         seen;
        clear_mon();
        chk = 8'h30 ^ 8'h08;
        send_byte(SOF);
        send_byte(8'h30);
        send_byte(8'h08);
        for (int i = 0; i < 8; i++) begin
            frameData[i] = 8'($urandom);
            chk = chk ^ frameData[i];
            send_byte(frameData[i]);
        end
        send_byte(chk);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (wq.size() >= 3) seen = 1'b1;
            else @(negedge i_Clock);
        end
        nChecks++;
        if (!seen) begin
            nFails++;
            $display("[TB] FAIL rst_commit_wait: got %0d writes want 3 within budget", wq.size());
        end
        i_Rst_n = 1'b0;
        #1;
        nChecks++;
        if ((o_Wr_En !== 1'b0) || (o_Busy !== 1'b0)) begin
            nFails++;
            $display("[TB] FAIL rst_commit_async: got wr_en %b busy %b want 0 0", o_Wr_En, o_Busy);
        end
        repeat (3) @(negedge i_Clock);
        #1 i_Rst_n = 1'b1;
        repeat (12) @(negedge i_Clock);
        nChecks++;
        if ((wq.size() !== 3) || (doneCnt !== 0) || (errCnt !== 0)) begin
            nFails++;
            $display("[TB] FAIL rst_commit_abort: got %0d writes %0d done %0d err want 3 0 0",
                     wq.size(), doneCnt, errCnt);
        end
        for (int i = 0; i < 4; i++) frameData[i] = 8'($urandom);
        run_frame(8'h90, 8'h04, -1, 1'b0, 1, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] addr;
        logic [7:0] lenB;
        int         chkMode;
        bit         ovr;
        for (int n = 0; n < 24; n++) begin
            for (int g = 0; g < $urandom_range(0, 2); g++) send_byte(garbage_byte());
            addr = 8'($urandom);
            if ($urandom_range(0, 5) == 0)
                lenB = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            else
                lenB = 8'($urandom_range(1, MAX_LEN));
            for (int i = 0; i < MAX_LEN; i++) frameData[i] = 8'($urandom);
            chkMode = ($urandom_range(0, 3) == 0) ? -2 : -1;
            ovr     = (lenB >= 8'd3) && ($urandom_range(0, 4) == 0);
            run_frame(addr, lenB, chkMode, ovr, 3, "random");
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_wrap_and_garbage();
        test_overrun();
        test_reset_mid_commit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
